// File: rtl/inst_fetch_stage.sv
// IF stage: PC register, combinational ROM addressing and the IF/ID pipeline register.
// Optional performance counters are enabled with INST_FETCH_PERF_EN.
module inst_fetch_stage #(
  parameter int unsigned PC_W   = 6,
  parameter int unsigned INST_W = 32,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              br_taken,
  input  logic [PC_W-1:0]   br_target,
  output logic [PC_W-1:0]   rom_addr,
  input  logic [INST_W-1:0] rom_inst,
  output logic [PC_W-1:0]   pc,
  output logic [INST_W-1:0] if_id_inst,
  output logic [PC_W-1:0]   if_id_pc,
  output logic [PC_W-1:0]   if_id_pc1,
  output logic              if_id_valid,
  output logic [CNT_W-1:0]  fetch_cnt,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  logic [PC_W-1:0] pc_inc;

  assign pc_inc   = pc + PC_W'(1);
  assign rom_addr = pc;

  // Redirect beats stall; a redirect turns the in-flight fetch into a bubble.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc          <= '0;
      if_id_inst  <= '0;
      if_id_pc    <= '0;
      if_id_pc1   <= '0;
      if_id_valid <= 1'b0;
    end else if (br_taken) begin
      pc          <= br_target;
      if_id_inst  <= '0;
      if_id_pc    <= pc;
      if_id_pc1   <= pc_inc;
      if_id_valid <= 1'b0;
    end else if (!stall) begin
      pc          <= pc_inc;
      if_id_inst  <= rom_inst;
      if_id_pc    <= pc;
      if_id_pc1   <= pc_inc;
      if_id_valid <= 1'b1;
    end
  end

`ifdef INST_FETCH_PERF_EN
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] fetch_q, stall_q, flush_q;

  // Saturating event counters, classified with the same priority as the pipeline update.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_q <= '0;
      stall_q <= '0;
      flush_q <= '0;
    end else if (br_taken) begin
      if (flush_q != CNT_MAX) flush_q <= flush_q + CNT_W'(1);
    end else if (stall) begin
      if (stall_q != CNT_MAX) stall_q <= stall_q + CNT_W'(1);
    end else begin
      if (fetch_q != CNT_MAX) fetch_q <= fetch_q + CNT_W'(1);
    end
  end

  assign fetch_cnt = fetch_q;
  assign stall_cnt = stall_q;
  assign flush_cnt = flush_q;
`else
  assign fetch_cnt = '0;
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule
